// File: rtl/leaf_arb_pkg.sv
// rtl/leaf_arb_pkg.sv - shared constants and types for the leaf quad arbiter
package leaf_arb_pkg;

    localparam int PKT_W     = 49;
    localparam int NUM_PORTS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } arb_state_t;

    typedef logic [PKT_W-1:0] pkt_t;

endpackage

// File: rtl/leaf_arb_fifo.sv
// rtl/leaf_arb_fifo.sv - per-port ingress FIFO with first-word-fall-through head
module leaf_arb_fifo #(
    parameter int W     = 49,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          do_pop;
    logic          do_push;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO may still accept.
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy tracking; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is readable.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/leaf_quad_arbiter.sv
// rtl/leaf_quad_arbiter.sv - four-leaf round-robin merge onto one BFT port with hold on backpressure
module leaf_quad_arbiter #(
    parameter int PKT_W      = leaf_arb_pkg::PKT_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PKT_W-1:0] din_leaf_interface2arb_0,
    input  logic [PKT_W-1:0] din_leaf_interface2arb_1,
    input  logic [PKT_W-1:0] din_leaf_interface2arb_2,
    input  logic [PKT_W-1:0] din_leaf_interface2arb_3,
    output logic             resend_leaf_0,
    output logic             resend_leaf_1,
    output logic             resend_leaf_2,
    output logic             resend_leaf_3,
    input  logic             ap_start_0,
    input  logic             ap_start_1,
    input  logic             ap_start_2,
    input  logic             ap_start_3,
    output logic [PKT_W-1:0] dout_arb2bft,
    input  logic             resend_bft,
    output logic [1:0]       grant_id
);

    import leaf_arb_pkg::*;

    logic [PKT_W-1:0]     din  [NUM_PORTS];
    logic [PKT_W-1:0]     head [NUM_PORTS];
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] ap_start;
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] resend_q;

    arb_state_t state;
    logic [1:0] last_grant;
    logic [1:0] winner;
    logic [1:0] cand;
    logic       any_elig;
    logic       arb_now;

    assign din[0]   = din_leaf_interface2arb_0;
    assign din[1]   = din_leaf_interface2arb_1;
    assign din[2]   = din_leaf_interface2arb_2;
    assign din[3]   = din_leaf_interface2arb_3;
    assign ap_start = {ap_start_3, ap_start_2, ap_start_1, ap_start_0};

    assign resend_leaf_0 = resend_q[0];
    assign resend_leaf_1 = resend_q[1];
    assign resend_leaf_2 = resend_q[2];
    assign resend_leaf_3 = resend_q[3];

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
        assign push[k] = din[k][PKT_W-1];

        leaf_arb_fifo #(
            .W     (PKT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (push[k]),
            .push_data (din[k]),
            .pop       (pop[k]),
            .head      (head[k]),
            .full      (full[k]),
            .empty     (empty[k])
        );
    end

    assign eligible = ~empty & ap_start;

    // A new arbitration happens unless the packet on the bus was just refused;
    // in IDLE nothing is on the bus, so a refusal there means nothing.
    assign arb_now = (state == ST_IDLE) || !resend_bft;

    // Round-robin pick: first eligible port scanning upward from last_grant + 1.
    always_comb begin
        any_elig = 1'b0;
        winner   = '0;
        cand     = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = last_grant + 2'(i + 1);
            if (!any_elig && eligible[cand]) begin
                any_elig = 1'b1;
                winner   = cand;
            end
        end
    end

    assign pop = (arb_now && any_elig) ? (NUM_PORTS'(1) << winner) : '0;

    // Drop notice: a full FIFO that is not draining this cycle loses the packet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resend_q <= '0;
        end else begin
            resend_q <= push & full & ~pop;
        end
    end

    // Output FSM: present a fresh winner, re-present on refusal, or go idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            dout_arb2bft <= '0;
            grant_id     <= '0;
            last_grant   <= 2'd3;
        end else if (arb_now) begin
            if (any_elig) begin
                state        <= ST_SEND;
                dout_arb2bft <= head[winner];
                grant_id     <= winner;
                last_grant   <= winner;
            end else begin
                state        <= ST_IDLE;
                dout_arb2bft <= '0;
            end
        end else begin
            state <= ST_HOLD;
        end
    end

endmodule

// File: doc/leaf_quad_arbiter.md
LEAF_QUAD_ARBITER -- requirements
Module: leaf_quad_arbiter

Interface
REQ-001 Parameter PKT_W, default 49, packet width; bit PKT_W-1 is the valid flag, bits PKT_W-2:0 are payload.
REQ-002 Parameter FIFO_DEPTH, default 2, entries per port ingress FIFO; legal values are powers of two, at least 2.
REQ-003 clk  input  1  single clock; all state SHALL be clocked on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 din_leaf_interface2arb_k  input  PKT_W  packet from leaf k, for k = 0..3.
REQ-006 resend_leaf_k  output  1  drop notice to leaf k: retransmit the last packet sent.
REQ-007 ap_start_k  input  1  port k enable; the port is eligible for grant only while this is high.
REQ-008 dout_arb2bft  output  PKT_W  merged packet stream to the BFT port.
REQ-009 resend_bft  input  1  BFT did not accept the packet presented in the previous cycle.
REQ-010 grant_id  output  2  index of the port whose packet is on dout_arb2bft; valid only when dout_arb2bft[PKT_W-1] = 1.

Function
REQ-011 Each port SHALL own a FIFO_DEPTH-entry FIFO; din with its valid bit = 1 SHALL be pushed at the clock edge where it is sampled, unless the FIFO is full.
REQ-012 Input with valid bit = 0 SHALL be ignored.
REQ-013 Full with no pop in the same cycle: the packet SHALL be dropped, and resend_leaf_k SHALL be 1 for exactly the next cycle.
REQ-014 Full with a pop in the same cycle: the push SHALL be accepted, with no drop and no resend.
REQ-015 FSM states: IDLE (dout invalid), SEND (new packet presented), HOLD (previous packet re-presented).
REQ-016 IDLE or SEND, at least one eligible port (FIFO non-empty and ap_start_k = 1): pop the round-robin winner, register it onto dout_arb2bft and grant_id, and go to SEND.
REQ-017 IDLE or SEND, no eligible port: go to IDLE with dout_arb2bft = 0.
REQ-018 Round-robin search SHALL start at (last_grant + 1) mod 4; last_grant SHALL update only on a pop.
REQ-019 SEND with resend_bft = 1: go to HOLD; dout_arb2bft and grant_id SHALL stay unchanged and no FIFO SHALL pop.
REQ-020 HOLD with resend_bft = 1: stay in HOLD and keep the output.
REQ-021 HOLD with resend_bft = 0: the held packet has been accepted; arbitrate as in IDLE or SEND (REQ-016/017).
REQ-022 resend_bft while in IDLE SHALL be ignored.
REQ-023 Latency: a packet sampled at edge t into an empty, idle, sole-eligible port SHALL appear on dout_arb2bft after edge t+1.
REQ-024 Throughput: at most one packet per cycle; back-to-back grants SHALL be allowed.
REQ-025 ap_start_k deasserted: port k SHALL keep accepting pushes but SHALL not be granted.
REQ-026 Deasserting ap_start_k SHALL not abort a HOLD already in progress for port k.
REQ-027 Payload SHALL pass through bit-exact; the block SHALL not modify any field.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 While reset = 0: dout_arb2bft = 0, grant_id = 0, resend_leaf_k = 0, all FIFOs empty, FSM = IDLE, last_grant = 3 (first search starts at port 0).
REQ-030 Reset mid-HOLD or with non-empty FIFOs SHALL discard all buffered packets, with no resend notice issued.
REQ-031 Reset deassertion SHALL be synchronized externally; the block SHALL not add a synchronizer.

Structure
REQ-032 Shared package leaf_arb_pkg SHALL hold PKT_W, NUM_PORTS = 4, the FSM state enum and the packet typedef.
REQ-033 One sub-module, leaf_arb_fifo (per-port FIFO with push, pop, full and empty), SHALL be instantiated four times.
REQ-034 The arbiter and FSM SHALL live in the top module.

Verification
REQ-035 Single packet: port 2 sends 0x1_0000_0000_00AB at edge 10 -> dout shows that packet after edge 11, grant_id = 2, then IDLE.
REQ-036 Fairness: all four ports hold 2 packets each from reset -> grant order 0,1,2,3,0,1,2,3 over 8 consecutive cycles.
REQ-037 Backpressure: resend_bft = 1 for 3 cycles after the first grant -> the same packet is held 4 cycles, no pop, and order is then preserved.
REQ-038 Overflow: port 1 sends 3 back-to-back packets while ap_start_1 = 0 -> the third is dropped, resend_leaf_1 pulses 1 cycle, and 2 packets emerge after ap_start_1 = 1.
REQ-039 Simultaneous: port 0 is full and granted in the same cycle that a new packet arrives -> no drop, no resend, 2 entries remain.
REQ-040 Reset while in HOLD with 2 packets buffered in port 3 -> all outputs are 0 next cycle and no stale packets appear after reset is released.
